// File: rtl/sp_ram_stream_reader.sv
// Read-side initiator for a single-port RAM: fetches a block of consecutive words
// and presents them as a valid/ready stream, hiding the one-cycle read latency.
module sp_ram_stream_reader #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    output logic                    m_valid_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES     = ADDR_WIDTH'(BE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK     = ~(WORD_BYTES - ADDR_WIDTH'(1'b1));
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(RAM_SIZE - BE_WIDTH);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO       = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE        = LEN_WIDTH'(1'b1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  issue_left_r;
    logic [LEN_WIDTH-1:0]  out_left_r;
    logic                  inflight_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            fifo_cnt_r;

    logic                  run_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  last_pop_s;
    logic                  issue_s;
    logic                  start_run_s;
    logic                  start_zero_s;
    logic [2:0]            occupancy_s;
    logic [2:0]            limit_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;

    assign run_s        = (state_r == ST_RUN);
    assign valid_s      = (fifo_cnt_r != 2'd0);
    assign pop_s        = valid_s & m_ready_i;
    assign last_pop_s   = pop_s & (out_left_r == LEN_ONE);
    assign start_run_s  = (state_r == ST_IDLE) & start_i & (len_i != LEN_ZERO);
    assign start_zero_s = (state_r == ST_IDLE) & start_i & (len_i == LEN_ZERO);

    // Issue a read only when the buffer plus the in-flight word leave room after this cycle's pop.
    always_comb begin
        occupancy_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r};
        limit_s     = 3'd2 + {2'b00, pop_s};
        issue_s     = 1'b0;
        if (run_s && (issue_left_r != LEN_ZERO) && (occupancy_s < limit_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Word-address increment wrapping at the top of the RAM.
    always_comb begin
        next_addr_s = addr_r + WORD_BYTES;
        if (addr_r == LAST_WORD_ADDR) begin
            next_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
            next_addr_s = addr_r + WORD_BYTES;
        end
    end

    // Transfer control: state, read address and the issue/output word counters.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            issue_left_r <= LEN_ZERO;
            out_left_r   <= LEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_run_s) begin
                        state_r      <= ST_RUN;
                        addr_r       <= base_addr_i & ALIGN_MASK;
                        issue_left_r <= len_i;
                        out_left_r   <= len_i;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        addr_r       <= next_addr_s;
                        issue_left_r <= issue_left_r - LEN_ONE;
                    end
                    if (pop_s) begin
                        out_left_r <= out_left_r - LEN_ONE;
                    end
                    if (last_pop_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer; capture follows the read request by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            inflight_r    <= 1'b0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
            fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (inflight_r) begin
                fifo_mem_r[wr_ptr_r] <= ram_rdata_i;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    // Completion pulse, one cycle after the final pop or a zero-length start.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_pop_s | start_zero_s;
        end
    end

    assign busy_o      = run_s;
    assign done_o      = done_r;
    assign ram_en_o    = issue_s;
    assign ram_addr_o  = addr_r;
    assign ram_we_o    = 1'b0;
    assign ram_be_o    = {BE_WIDTH{1'b1}};
    assign ram_wdata_o = {DATA_WIDTH{1'b0}};
    assign m_data_o    = fifo_mem_r[rd_ptr_r];
    assign m_valid_o   = valid_s;
    assign m_last_o    = valid_s & (out_left_r == LEN_ONE);

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
// Directed bench for sp_ram_stream_reader with a behavioural one-cycle-latency RAM.
module tb_sp_ram_stream_reader;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [14:0] base_addr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        ram_en_o;
    logic [14:0] ram_addr_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:8191];

    sp_ram_stream_reader dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 8192; k++) mem[k] = 32'hA000_0000 + 32'(k);
    end

    always @(posedge clk) begin
        if (ram_en_o) ram_rdata_i <= mem[ram_addr_o[14:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream();
        base_addr_i = 15'h0100;
        len_i       = 16'd4;
        start_i     = 1'b1;
        m_ready_i   = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            chk("st_en", 64'(ram_en_o), 64'(c <= 4));
            if (c <= 4) chk("st_addr", 64'(ram_addr_o), 64'(32'h100 + 32'(4 * (c - 1))));
            chk("st_valid", 64'(m_valid_o), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("st_data", 64'(m_data_o), 64'(32'hA000_0040 + 32'(c - 3)));
            chk("st_last", 64'(m_last_o), 64'(c == 6));
            chk("st_done", 64'(done_o), 64'(c == 7));
            chk("st_busy", 64'(busy_o), 64'(c <= 6));
            step();
        end
    endtask

    initial begin
        logic [39:0] pat;
        int          issued;
        int          popped;
        logic        prev_last;
        logic        held_valid;
        logic [31:0] held_data;
        logic        finished;

        rst_i = 1'b1; start_i = 1'b0; base_addr_i = 15'h0; len_i = 16'd0; m_ready_i = 1'b0;
        step();
        step();
        // Reset values
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_en", 64'(ram_en_o), 64'd0);
        chk("rst_addr", 64'(ram_addr_o), 64'd0);
        chk("rst_we", 64'(ram_we_o), 64'd0);
        chk("rst_be", 64'(ram_be_o), 64'hF);
        chk("rst_wdata", 64'(ram_wdata_o), 64'd0);
        chk("rst_data", 64'(m_data_o), 64'd0);
        chk("rst_valid", 64'(m_valid_o), 64'd0);
        chk("rst_last", 64'(m_last_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Streaming at full rate
        run_stream();

        // Backpressure with an irregular ready pattern
        pat = 40'b1001_0110_0011_1010_0101_1100_1101_0011_0111_0100;
        issued = 0; popped = 0; prev_last = 1'b0; held_valid = 1'b0; held_data = 32'h0;
        finished = 1'b0;
        base_addr_i = 15'h0100; len_i = 16'd8; start_i = 1'b1; m_ready_i = 1'b0;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 80 && !finished; i++) begin
            m_ready_i = pat[i % 40];
            #1;
            chk("bp_done", 64'(done_o), 64'(prev_last));
            if (held_valid) begin
                chk("bp_hold_valid", 64'(m_valid_o), 64'd1);
                chk("bp_hold_data", 64'(m_data_o), 64'(held_data));
            end
            if (ram_en_o) begin
                chk("bp_addr", 64'(ram_addr_o), 64'(32'h100 + 32'(4 * issued)));
                issued++;
            end
            if (m_valid_o && m_ready_i) begin
                chk("bp_data", 64'(m_data_o), 64'(32'hA000_0040 + 32'(popped)));
                chk("bp_last", 64'(m_last_o), 64'(popped == 7));
                popped++;
                prev_last = (popped == 8);
            end else begin
                prev_last = 1'b0;
            end
            chk("bp_credit", 64'(issued - popped <= 2), 64'd1);
            held_valid = m_valid_o && !m_ready_i;
            held_data  = m_data_o;
            if (done_o) finished = 1'b1;
            step();
        end
        chk("bp_popped", 64'(popped), 64'd8);
        chk("bp_issued", 64'(issued), 64'd8);
        chk("bp_finished", 64'(finished), 64'd1);

        // Address wrap at the top of the RAM
        base_addr_i = 15'h7FFC; len_i = 16'd3; start_i = 1'b1; m_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("wr_en", 64'(ram_en_o), 64'(c <= 3));
            if (c == 1) chk("wr_addr0", 64'(ram_addr_o), 64'h7FFC);
            if (c == 2) chk("wr_addr1", 64'(ram_addr_o), 64'h0000);
            if (c == 3) chk("wr_addr2", 64'(ram_addr_o), 64'h0004);
            chk("wr_valid", 64'(m_valid_o), 64'(c >= 3 && c <= 5));
            if (c == 3) chk("wr_data0", 64'(m_data_o), 64'hA000_1FFF);
            if (c == 4) chk("wr_data1", 64'(m_data_o), 64'hA000_0000);
            if (c == 5) chk("wr_data2", 64'(m_data_o), 64'hA000_0001);
            chk("wr_last", 64'(m_last_o), 64'(c == 5));
            chk("wr_done", 64'(done_o), 64'(c == 6));
            step();
        end

        // Zero-length start
        base_addr_i = 15'h0200; len_i = 16'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        #1;
        chk("z_done", 64'(done_o), 64'd1);
        chk("z_en", 64'(ram_en_o), 64'd0);
        chk("z_busy", 64'(busy_o), 64'd0);
        step();
        chk("z_done_clr", 64'(done_o), 64'd0);
        chk("z_en2", 64'(ram_en_o), 64'd0);

        // Start pulses while running are ignored
        base_addr_i = 15'h0200; len_i = 16'd2; start_i = 1'b1;
        step();
        for (int c = 1; c <= 5; c++) begin
            start_i     = (c <= 3);
            base_addr_i = 15'h0300;
            len_i       = 16'd5;
            #1;
            chk("sb_en", 64'(ram_en_o), 64'(c <= 2));
            if (c <= 2) chk("sb_addr", 64'(ram_addr_o), 64'(32'h200 + 32'(4 * (c - 1))));
            chk("sb_valid", 64'(m_valid_o), 64'(c >= 3 && c <= 4));
            if (c >= 3 && c <= 4) chk("sb_data", 64'(m_data_o), 64'(32'hA000_0080 + 32'(c - 3)));
            chk("sb_last", 64'(m_last_o), 64'(c == 4));
            chk("sb_done", 64'(done_o), 64'(c == 5));
            chk("sb_busy", 64'(busy_o), 64'(c <= 4));
            step();
        end
        start_i = 1'b0;
        step();

        // Reset in cycle 4 of a 16-word transfer
        base_addr_i = 15'h0100; len_i = 16'd16; start_i = 1'b1; m_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mr_busy", 64'(busy_o), 64'd0);
        chk("mr_done", 64'(done_o), 64'd0);
        chk("mr_en", 64'(ram_en_o), 64'd0);
        chk("mr_valid", 64'(m_valid_o), 64'd0);
        chk("mr_last", 64'(m_last_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mr_quiet_valid", 64'(m_valid_o), 64'd0);
            chk("mr_quiet_en", 64'(ram_en_o), 64'd0);
        end
        run_stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
